mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the data and address width.
REQ-002 SHALL have parameter MBE_W, default XLEN/8, meaning the byte-enable width.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port valid_in, input, 1, meaning packet_in holds a live EX/MEM instruction.
REQ-006 SHALL have port packet_in, input, rv32i_packet_t, meaning the EX/MEM buffer output.
REQ-007 SHALL have port advance, input, 1, meaning the MEM/WB buffer loads this cycle.
REQ-008 SHALL have port flush, input, 1, meaning kill the current instruction.
REQ-009 SHALL have port stall_out, output, 1, meaning freeze all pipeline buffers.
REQ-010 SHALL have port packet_out, output, rv32i_packet_t, meaning packet_in with the memwb fields (mdrreg_out, rmask, wmask, mem_addr, mem_rdata, mem_wdata) filled.
REQ-011 SHALL have ports data_read and data_write, output, 1 each; data_mbe, output, MBE_W; data_addr, output, XLEN; data_wdata, output, XLEN.
REQ-012 SHALL have ports data_rdata, input, XLEN, and data_resp, input, 1.

Function
REQ-013 SHALL implement an FSM with states IDLE, ACCESS, DONE.
REQ-014 SHALL treat a packet as a memory op when valid_in is high and ctrl.mem_read or ctrl.mem_write is set.
REQ-015 IDLE: on a memory op with flush low, SHALL go to ACCESS and register the address, mask, wdata and read/write.
REQ-016 IDLE: on a non-memory op, SHALL not stall and SHALL pass the packet with zero masks.
REQ-017 ACCESS: SHALL drive data_read/data_write from registers and hold them and all request fields stable until data_resp.
REQ-018 ACCESS: on data_resp, SHALL capture data_rdata, drop the request on the next edge, and go to DONE.
REQ-019 DONE: on advance, SHALL go to IDLE; otherwise SHALL hold the captured data.
REQ-020 stall_out SHALL equal (IDLE and memory op and not flush) or ACCESS.
REQ-021 Latency: the request SHALL be visible 1 cycle after the op arrives, and stall_out SHALL go low the cycle after data_resp.
REQ-022 data_addr SHALL be {alu_out[XLEN-1:2], 2'b00}, and mem_addr SHALL be the same value.
REQ-023 Stores SHALL use these masks, with off = alu_out[1:0]:
- SB: wmask = 4'b0001<<off, wdata = rs2[7:0] replicated ×4.
- SH: wmask = 4'b0011<<off, wdata = rs2[15:0] replicated ×2.
- SW: wmask = 4'b1111, wdata = rs2.
REQ-024 Loads SHALL set rmask with the same shapes, select the byte or half lane by off, and sign-extend (LB/LH) or zero-extend (LBU/LHU) into mdrreg_out; LW passes the word unchanged.
REQ-025 mem_rdata SHALL carry the raw captured word.
REQ-026 flush during ACCESS SHALL NOT cancel the request; the FSM SHALL wait for data_resp, discard the data, then go to IDLE, not DONE.
REQ-027 flush in IDLE or DONE SHALL force IDLE next cycle, and a flushed result SHALL produce zero masks.
REQ-028 An unknown funct3 on a memory op SHALL be treated as a word access.

Reset
REQ-029 rst SHALL force IDLE and clear all request and captured-data registers.
REQ-030 Outputs after rst SHALL be: data_read=0, data_write=0, data_mbe=0, data_addr=0, data_wdata=0, stall_out=0.
REQ-031 rst in ACCESS SHALL drop the request at the next edge, and any later data_resp SHALL be ignored.

Configuration
REQ-032 With MEM_STAGE_MISALIGN_CHECK_EN defined, a misaligned access SHALL not be issued, SHALL not stall, and SHALL set packet_out.data.misaligned=1 with zero masks.
- Misaligned means LH/LHU/SH with off[0]=1, or LW/SW with off≠0.
REQ-033 Without MEM_STAGE_MISALIGN_CHECK_EN, low address bits beyond the lane SHALL be ignored, and misaligned SHALL remain 0.

Structure
REQ-034 The enum mem_state_t and the funct3 load/store constants SHALL live in rv32i_types.
REQ-035 Lane formatting (masks, wdata replication, load extension) SHALL be the combinational sub-module mem_align.

Verification
REQ-036 Scenario: SW, alu_out=0x100, rs2=0xDEADBEEF, resp after 3 cycles -> data_write=1, data_mbe=1111, data_addr=0x100, stall held 4 cycles.
REQ-037 Scenario: LB, alu_out=0x203, rdata=0x80000000 -> rmask=1000, mdrreg_out=0xFFFFFF80; LBU gives 0x00000080.
REQ-038 Scenario: SH, alu_out=0x302, rs2=0x1234 -> data_mbe=1100, data_wdata=0x12341234.
REQ-039 Scenario: flush in ACCESS, resp 2 cycles later -> request held until resp, then IDLE with zero masks out.
REQ-040 Scenario: rst asserted in ACCESS -> data_read=0 at the next edge, and a stale data_resp causes no state change.
REQ-041 Scenario: with the macro defined, LW at 0x101 -> no request, stall_out=0, misaligned=1.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types for the memory stage: FSM states, funct3 codes, packet layout.
package rv32i_types;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned MASK_W = WORD_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [2:0] funct3;
    } ctrl_t;

    typedef struct packed {
        logic [WORD_W-1:0] alu_out;
        logic [WORD_W-1:0] rs2_v;
        logic              misaligned;
    } data_t;

    typedef struct packed {
        logic [WORD_W-1:0] mdrreg_out;
        logic [MASK_W-1:0] rmask;
        logic [MASK_W-1:0] wmask;
        logic [WORD_W-1:0] mem_addr;
        logic [WORD_W-1:0] mem_rdata;
        logic [WORD_W-1:0] mem_wdata;
    } memwb_t;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        ctrl_t             ctrl;
        data_t             data;
        memwb_t            memwb;
    } rv32i_packet_t;

endpackage

// File: rtl/mem_align.sv
// Lane formatting: byte-enable shape, store data replication and load extension.
module mem_align
    import rv32i_types::*;
(
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        off_i,
    input  logic [WORD_W-1:0] rs2_i,
    input  logic [WORD_W-1:0] rdata_i,
    output logic [MASK_W-1:0] mask_o,
    output logic [WORD_W-1:0] wdata_o,
    output logic [WORD_W-1:0] load_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Halfword lanes only look at off[1]; words ignore the offset entirely.
    always_comb begin
        mask_o  = 4'b1111;
        wdata_o = rs2_i;
        case (funct3_i)
            F3_SB, F3_LBU: begin
                mask_o  = 4'b0001 << off_i;
                wdata_o = {4{rs2_i[7:0]}};
            end
            F3_SH, F3_LHU: begin
                mask_o  = 4'b0011 << {off_i[1], 1'b0};
                wdata_o = {2{rs2_i[15:0]}};
            end
            F3_SW: begin
                mask_o  = 4'b1111;
                wdata_o = rs2_i;
            end
            default: begin
                mask_o  = 4'b1111;
                wdata_o = rs2_i;
            end
        endcase
    end

    always_comb begin
        byte_v = rdata_i[{off_i, 3'b000} +: 8];
        half_v = rdata_i[{off_i[1], 4'b0000} +: 16];
        case (funct3_i)
            F3_LB:   load_o = {{24{byte_v[7]}}, byte_v};
            F3_LBU:  load_o = {24'b0, byte_v};
            F3_LH:   load_o = {{16{half_v[15]}}, half_v};
            F3_LHU:  load_o = {16'b0, half_v};
            F3_LW:   load_o = rdata_i;
            default: load_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: issues one data-memory request per load/store and stalls until data_resp.
// Optional MEM_STAGE_MISALIGN_CHECK_EN: misaligned accesses are flagged and never issued.
module mem_stage
    import rv32i_types::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned MBE_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  rv32i_packet_t     packet_in,
    input  logic              advance,
    input  logic              flush,
    output logic              stall_out,
    output rv32i_packet_t     packet_out,
    output logic              data_read,
    output logic              data_write,
    output logic [MBE_W-1:0]  data_mbe,
    output logic [XLEN-1:0]   data_addr,
    output logic [XLEN-1:0]   data_wdata,
    input  logic [XLEN-1:0]   data_rdata,
    input  logic              data_resp
);

    mem_state_t state_q, state_d;

    logic             read_q, write_q, load_q, kill_q;
    logic [MBE_W-1:0] mbe_q;
    logic [XLEN-1:0]  addr_q, wdata_q, rdata_q;
    logic [2:0]       funct3_q;
    logic [1:0]       off_q;

    logic              mem_op_c, mis_c, issue_c, idle_c;
    logic [2:0]        al_funct3;
    logic [1:0]        al_off;
    logic [MASK_W-1:0] al_mask;
    logic [WORD_W-1:0] al_wdata, al_load;

    assign mem_op_c = valid_in && (packet_in.ctrl.mem_read || packet_in.ctrl.mem_write);
    assign idle_c   = (state_q == IDLE);

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    always_comb begin
        mis_c = 1'b0;
        case (packet_in.ctrl.funct3)
            F3_LB, F3_LBU: mis_c = 1'b0;
            F3_LH, F3_LHU: mis_c = packet_in.data.alu_out[0];
            default:       mis_c = (packet_in.data.alu_out[1:0] != 2'b00);
        endcase
    end
`else
    assign mis_c = 1'b0;
`endif

    assign issue_c = mem_op_c && !flush && !mis_c;

    // Shared formatter: incoming op while idle, captured op afterwards.
    assign al_funct3 = idle_c ? packet_in.ctrl.funct3 : funct3_q;
    assign al_off    = idle_c ? packet_in.data.alu_out[1:0] : off_q;

    mem_align u_align (
        .funct3_i (al_funct3),
        .off_i    (al_off),
        .rs2_i    (packet_in.data.rs2_v),
        .rdata_i  (WORD_W'(rdata_q)),
        .mask_o   (al_mask),
        .wdata_o  (al_wdata),
        .load_o   (al_load)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // A flush seen at any point of the access sends the FSM back to IDLE instead of DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue_c) state_d = ACCESS;
            ACCESS:  if (data_resp) state_d = (kill_q || flush) ? IDLE : DONE;
            DONE:    if (advance || flush) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_out                 = (idle_c && issue_c) || (state_q == ACCESS);
        packet_out                = packet_in;
        packet_out.data.misaligned = 1'b0;
        packet_out.memwb          = '0;
        case (state_q)
            IDLE: packet_out.data.misaligned = mem_op_c && !flush && mis_c;
            ACCESS, DONE: begin
                packet_out.memwb.mem_addr  = WORD_W'(addr_q);
                packet_out.memwb.mem_rdata = WORD_W'(rdata_q);
                packet_out.memwb.mem_wdata = WORD_W'(wdata_q);
                if (!flush && !(state_q == ACCESS && kill_q)) begin
                    packet_out.memwb.rmask      = load_q ? MASK_W'(mbe_q) : '0;
                    packet_out.memwb.wmask      = load_q ? '0 : MASK_W'(mbe_q);
                    packet_out.memwb.mdrreg_out = load_q ? al_load : '0;
                end
            end
            default: packet_out.memwb = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            load_q   <= 1'b0;
            kill_q   <= 1'b0;
            mbe_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            funct3_q <= '0;
            off_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (issue_c) begin
                    read_q   <= packet_in.ctrl.mem_read;
                    write_q  <= packet_in.ctrl.mem_write && !packet_in.ctrl.mem_read;
                    load_q   <= packet_in.ctrl.mem_read;
                    kill_q   <= 1'b0;
                    mbe_q    <= MBE_W'(al_mask);
                    addr_q   <= XLEN'({packet_in.data.alu_out[WORD_W-1:2], 2'b00});
                    wdata_q  <= XLEN'(al_wdata);
                    funct3_q <= packet_in.ctrl.funct3;
                    off_q    <= packet_in.data.alu_out[1:0];
                end
                ACCESS: begin
                    if (flush) kill_q <= 1'b1;
                    if (data_resp) begin
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        if (!kill_q && !flush) rdata_q <= data_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_read  = read_q;
    assign data_write = write_q;
    assign data_mbe   = mbe_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;
    import rv32i_types::*;

    logic          clk = 1'b0;
    logic          rst, valid_in, advance, flush, data_resp;
    rv32i_packet_t packet_in, packet_out;
    logic          stall_out, data_read, data_write;
    logic [3:0]    data_mbe;
    logic [31:0]   data_addr, data_wdata, data_rdata;

    int checks   = 0;
    int failures = 0;
    int stall_cnt;

    mem_stage #(.XLEN(32), .MBE_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .packet_in  (packet_in),
        .advance    (advance),
        .flush      (flush),
        .stall_out  (stall_out),
        .packet_out (packet_out),
        .data_read  (data_read),
        .data_write (data_write),
        .data_mbe   (data_mbe),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata),
        .data_resp  (data_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [31:0] rs2);
        packet_in                 = '0;
        packet_in.pc              = 32'h0000_1000;
        packet_in.ctrl.mem_read   = rd;
        packet_in.ctrl.mem_write  = wr;
        packet_in.ctrl.funct3     = f3;
        packet_in.data.alu_out    = alu;
        packet_in.data.rs2_v      = rs2;
        valid_in                  = 1'b1;
    endtask

    task automatic retire();
        advance  = 1'b1;
        valid_in = 1'b0;
        tick();
        advance  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; advance = 1'b0; flush = 1'b0;
        data_resp = 1'b0; data_rdata = '0; packet_in = '0;
        tick(); tick(); #1;
        chk("rst_read",  32'(data_read), 0);
        chk("rst_write", 32'(data_write), 0);
        chk("rst_mbe",   32'(data_mbe), 0);
        chk("rst_addr",  data_addr, 0);
        chk("rst_wdata", data_wdata, 0);
        chk("rst_stall", 32'(stall_out), 0);
        rst = 1'b0;
        tick();

        // SW, response in third access cycle: four stalled cycles
        stall_cnt = 0;
        set_op(1'b0, 1'b1, F3_SW, 32'h0000_0100, 32'hDEAD_BEEF); #1;
        chk("sw_idle_stall", 32'(stall_out), 1);
        if (stall_out) stall_cnt++;
        tick(); #1;
        chk("sw_write", 32'(data_write), 1);
        chk("sw_read",  32'(data_read), 0);
        chk("sw_mbe",   32'(data_mbe), 32'hF);
        chk("sw_addr",  data_addr, 32'h0000_0100);
        chk("sw_wdata", data_wdata, 32'hDEAD_BEEF);
        if (stall_out) stall_cnt++;
        tick(); #1;
        chk("sw_hold_write", 32'(data_write), 1);
        if (stall_out) stall_cnt++;
        tick(); data_resp = 1'b1; #1;
        if (stall_out) stall_cnt++;
        tick(); data_resp = 1'b0; #1;
        if (stall_out) stall_cnt++;
        chk("sw_stall_cycles", 32'(stall_cnt), 4);
        chk("sw_done_nostall", 32'(stall_out), 0);
        chk("sw_drop_write",   32'(data_write), 0);
        chk("sw_wmask",        32'(packet_out.memwb.wmask), 32'hF);
        chk("sw_mem_addr",     packet_out.memwb.mem_addr, 32'h0000_0100);
        chk("sw_mem_wdata",    packet_out.memwb.mem_wdata, 32'hDEAD_BEEF);
        retire(); #1;
        chk("sw_idle_wmask", 32'(packet_out.memwb.wmask), 0);

        // LB at 0x203, upper byte 0x80 sign-extends
        set_op(1'b1, 1'b0, F3_LB, 32'h0000_0203, 32'h0); tick(); #1;
        chk("lb_read", 32'(data_read), 1);
        chk("lb_mbe",  32'(data_mbe), 32'h8);
        chk("lb_addr", data_addr, 32'h0000_0200);
        data_rdata = 32'h8000_0000; data_resp = 1'b1;
        tick(); data_resp = 1'b0; data_rdata = 32'h0; #1;
        chk("lb_rmask",  32'(packet_out.memwb.rmask), 32'h8);
        chk("lb_mdr",    packet_out.memwb.mdrreg_out, 32'hFFFF_FF80);
        chk("lb_rdata",  packet_out.memwb.mem_rdata, 32'h8000_0000);
        chk("lb_wmask",  32'(packet_out.memwb.wmask), 0);
        tick(); #1;
        chk("lb_done_hold", packet_out.memwb.mdrreg_out, 32'hFFFF_FF80);
        retire();

        // LBU same address zero-extends
        set_op(1'b1, 1'b0, F3_LBU, 32'h0000_0203, 32'h0); tick();
        data_rdata = 32'h8000_0000; data_resp = 1'b1;
        tick(); data_resp = 1'b0; #1;
        chk("lbu_mdr", packet_out.memwb.mdrreg_out, 32'h0000_0080);
        retire();

        // LH at 0x206 selects upper half and sign-extends
        set_op(1'b1, 1'b0, F3_LH, 32'h0000_0206, 32'h0); tick(); #1;
        chk("lh_mbe", 32'(data_mbe), 32'hC);
        data_rdata = 32'h8001_1234; data_resp = 1'b1;
        tick(); data_resp = 1'b0; #1;
        chk("lh_mdr", packet_out.memwb.mdrreg_out, 32'hFFFF_8001);
        retire();

        // SH at 0x302
        set_op(1'b0, 1'b1, F3_SH, 32'h0000_0302, 32'h0000_1234); tick(); #1;
        chk("sh_mbe",   32'(data_mbe), 32'hC);
        chk("sh_wdata", data_wdata, 32'h1234_1234);
        chk("sh_addr",  data_addr, 32'h0000_0300);
        data_resp = 1'b1; tick(); data_resp = 1'b0;
        retire();

        // SB at 0x101 replicates the byte into every lane
        set_op(1'b0, 1'b1, F3_SB, 32'h0000_0101, 32'h0000_00A5); tick(); #1;
        chk("sb_mbe",   32'(data_mbe), 32'h2);
        chk("sb_wdata", data_wdata, 32'hA5A5_A5A5);
        data_resp = 1'b1; tick(); data_resp = 1'b0;
        retire();

        // Flush during ACCESS: request held until resp, then IDLE with zero masks
        set_op(1'b1, 1'b0, F3_LW, 32'h0000_0400, 32'h0); tick();
        flush = 1'b1; #1;
        chk("fl_kill_rmask", 32'(packet_out.memwb.rmask), 0);
        tick(); flush = 1'b0; valid_in = 1'b0; #1;
        chk("fl_hold_read",  32'(data_read), 1);
        chk("fl_hold_stall", 32'(stall_out), 1);
        chk("fl_hold_addr",  data_addr, 32'h0000_0400);
        tick(); data_resp = 1'b1; data_rdata = 32'h0000_0055; #1;
        chk("fl_resp_stall", 32'(stall_out), 1);
        tick(); data_resp = 1'b0; #1;
        chk("fl_after_stall", 32'(stall_out), 0);
        chk("fl_after_read",  32'(data_read), 0);
        chk("fl_after_rmask", 32'(packet_out.memwb.rmask), 0);
        chk("fl_after_mdr",   packet_out.memwb.mdrreg_out, 0);

        // Reset mid-access: request drops, stale resp ignored
        set_op(1'b1, 1'b0, F3_LW, 32'h0000_0500, 32'h0); tick(); #1;
        chk("ra_read", 32'(data_read), 1);
        rst = 1'b1; tick(); rst = 1'b0; valid_in = 1'b0; #1;
        chk("ra_drop_read", 32'(data_read), 0);
        chk("ra_stall",     32'(stall_out), 0);
        chk("ra_addr",      data_addr, 0);
        data_resp = 1'b1; data_rdata = 32'h1111_2222; tick(); data_resp = 1'b0; #1;
        chk("ra_stale_stall", 32'(stall_out), 0);
        chk("ra_stale_rmask", 32'(packet_out.memwb.rmask), 0);
        chk("ra_stale_read",  32'(data_read), 0);

        // Non-memory op passes straight through
        set_op(1'b0, 1'b0, 3'b000, 32'h0000_0700, 32'h5); #1;
        chk("nm_stall", 32'(stall_out), 0);
        chk("nm_masks", 32'({packet_out.memwb.rmask, packet_out.memwb.wmask}), 0);
        chk("nm_pc",    packet_out.pc, 32'h0000_1000);
        tick(); #1;
        chk("nm_noreq", 32'(data_read | data_write), 0);

        // Flush in IDLE suppresses the op
        set_op(1'b1, 1'b0, F3_LW, 32'h0000_0800, 32'h0); flush = 1'b1; #1;
        chk("fi_stall", 32'(stall_out), 0);
        tick(); flush = 1'b0; valid_in = 1'b0; #1;
        chk("fi_noreq", 32'(data_read), 0);

        // Unknown funct3 behaves as a word access
        set_op(1'b1, 1'b0, 3'b011, 32'h0000_060E, 32'h0); tick(); #1;
        chk("uk_mbe",  32'(data_mbe), 32'hF);
        chk("uk_addr", data_addr, 32'h0000_060C);
        data_rdata = 32'hCAFE_F00D; data_resp = 1'b1;
        tick(); data_resp = 1'b0; #1;
        chk("uk_mdr", packet_out.memwb.mdrreg_out, 32'hCAFE_F00D);
        retire();

        // LW at 0x101
        set_op(1'b1, 1'b0, F3_LW, 32'h0000_0101, 32'h0); #1;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
        chk("mis_stall", 32'(stall_out), 0);
        chk("mis_flag",  32'(packet_out.data.misaligned), 1);
        chk("mis_rmask", 32'(packet_out.memwb.rmask), 0);
        tick(); valid_in = 1'b0; #1;
        chk("mis_noreq", 32'(data_read), 0);
`else
        chk("mis_stall", 32'(stall_out), 1);
        chk("mis_flag",  32'(packet_out.data.misaligned), 0);
        tick(); #1;
        chk("mis_read", 32'(data_read), 1);
        chk("mis_addr", data_addr, 32'h0000_0100);
        chk("mis_mbe",  32'(data_mbe), 32'hF);
        data_resp = 1'b1; tick(); data_resp = 1'b0;
        retire();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
